router_input_port: RTL and testbench

ROUTER_INPUT_PORT -- requirements
Module: router_input_port

---
 rtl/router_pkg.sv | 27 ++
 rtl/router_shift_in.sv | 50 +++++
 rtl/router_input_port.sv | 191 +++++++++++++++++++
 tb/tb_router_input_port.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared types and constants for the router input port:
//               FSM state encoding, address/byte widths, counter widths and
//               default padding / payload-limit values.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int ADDR_W          = 4;
    localparam int BYTE_W          = 8;
    localparam int BIT_CNT_W       = 3;
    localparam int BCNT_W          = 6;
    localparam int DEF_PAD_CYCLES  = 5;
    localparam int DEF_MAX_BYTES   = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_PAD   = 3'd2,
        ST_DATA  = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

endpackage : router_pkg
`default_nettype wire

// File: rtl/router_shift_in.sv
`default_nettype none
// ============================================================================
// Module      : router_shift_in
// Description : LSB-first serial-to-parallel shifter with a 3-bit bit counter.
//               byte_done flags the cycle in which the 8th sampled bit arrives;
//               byte_next is the full byte including that bit, so the parent
//               can register it with one cycle of latency.
// Ports       : clock, reset   - clock / synchronous active-high reset
//               clear          - synchronous clear of shifter and counter
//               shift_en       - sample din this cycle
//               din            - serial data bit
//               byte_next      - assembled byte (valid when byte_done=1)
//               byte_done      - this cycle's bit completes a byte
// Revision    : 1.0 - initial release
// ============================================================================
module router_shift_in
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              din,
    output logic [BYTE_W-1:0] byte_next,
    output logic              byte_done
);

    localparam logic [BIT_CNT_W-1:0] c_BIT_LAST = BIT_CNT_W'(BYTE_W - 1);

    // Only 7 bits are ever held; the 8th comes straight from din.
    logic [BYTE_W-2:0]    r_shreg;
    logic [BIT_CNT_W-1:0] r_bit_cnt;

    // New bits enter at the top and move down, so the first sampled bit
    // ends up in bit 0 of the completed byte.
    assign byte_next = {din, r_shreg};
    assign byte_done = shift_en && (r_bit_cnt == c_BIT_LAST);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (shift_en) begin
            r_shreg   <= {din, r_shreg[BYTE_W-2:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

endmodule : router_shift_in
`default_nettype wire

// File: rtl/router_input_port.sv
`default_nettype none
// ============================================================================
// Module      : router_input_port
// Description : Serial router input port. Decodes a frame of 4 address bits,
//               PAD_CYCLES padding cycles and a valid_n-qualified LSB-first
//               payload into address and byte strobes, flagging protocol
//               errors. All outputs are registered.
// Ports       : clock, reset     - clock / synchronous active-high reset
//               din              - serial data, LSB first
//               frame_n          - active-low frame (high on last data bit)
//               valid_n          - active-low payload bit qualifier
//               addr_o           - destination port of current packet
//               addr_valid_o     - one-cycle pulse, addr_o updated
//               byte_o           - assembled payload byte
//               byte_valid_o     - one-cycle pulse per completed byte
//               byte_last_o      - final byte of the packet
//               busy_o           - packet in progress
//               err_o            - one-cycle pulse on protocol violation
// Revision    : 1.0 - initial release
// ============================================================================
module router_input_port
    import router_pkg::*;
#(
    parameter int PAD_CYCLES = DEF_PAD_CYCLES,
    parameter int MAX_BYTES  = DEF_MAX_BYTES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              din,
    input  logic              frame_n,
    input  logic              valid_n,
    output logic [ADDR_W-1:0] addr_o,
    output logic              addr_valid_o,
    output logic [BYTE_W-1:0] byte_o,
    output logic              byte_valid_o,
    output logic              byte_last_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int                  c_PAD_W    = (PAD_CYCLES > 1) ? $clog2(PAD_CYCLES) : 1;
    localparam logic [c_PAD_W-1:0]  c_PAD_LAST = c_PAD_W'(PAD_CYCLES - 1);
    localparam logic [BCNT_W-1:0]   c_MAX_CNT  = BCNT_W'(MAX_BYTES);

    state_t              r_state;
    logic [1:0]          r_addr_cnt;
    logic [ADDR_W-2:0]   r_addr_sh;
    logic [c_PAD_W-1:0]  r_pad_cnt;
    logic [BCNT_W-1:0]   r_byte_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_addr_valid;
    logic [BYTE_W-1:0]   r_byte;
    logic                r_byte_valid;
    logic                r_byte_last;
    logic                r_busy;
    logic                r_err;

    logic                w_shift_en;
    logic                w_shift_clr;
    logic [BYTE_W-1:0]   w_byte_next;
    logic                w_byte_done;

    // The shifter is held clear outside DATA so every packet starts at bit 0.
    assign w_shift_en  = (r_state == ST_DATA) && !valid_n;
    assign w_shift_clr = (r_state != ST_DATA);

    router_shift_in u_shift_in (
        .clock     (clock),
        .reset     (reset),
        .clear     (w_shift_clr),
        .shift_en  (w_shift_en),
        .din       (din),
        .byte_next (w_byte_next),
        .byte_done (w_byte_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_addr_cnt   <= '0;
            r_addr_sh    <= '0;
            r_pad_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_addr       <= '0;
            r_addr_valid <= 1'b0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
            r_byte_last  <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            // Strobes default low so each lasts exactly one cycle.
            r_addr_valid <= 1'b0;
            r_byte_valid <= 1'b0;
            r_byte_last  <= 1'b0;
            r_err        <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // The falling frame_n cycle already carries address bit 0.
                    if (!frame_n) begin
                        r_addr_sh[0] <= din;
                        r_addr_cnt   <= 2'd1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    if (frame_n) begin
                        r_err   <= 1'b1;
                        r_state <= ST_FLUSH;
                    end else if (r_addr_cnt == 2'd3) begin
                        r_addr       <= {din, r_addr_sh};
                        r_addr_valid <= 1'b1;
                        r_pad_cnt    <= '0;
                        r_state      <= ST_PAD;
                    end else begin
                        r_addr_sh[r_addr_cnt] <= din;
                        r_addr_cnt            <= r_addr_cnt + 2'd1;
                    end
                end

                ST_PAD: begin
                    if (frame_n || !valid_n) begin
                        r_err   <= 1'b1;
                        r_state <= ST_FLUSH;
                    end else if (r_pad_cnt == c_PAD_LAST) begin
                        r_byte_cnt <= '0;
                        r_state    <= ST_DATA;
                    end else begin
                        r_pad_cnt <= r_pad_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (!valid_n) begin
                        if (w_byte_done) begin
                            if (r_byte_cnt == c_MAX_CNT) begin
                                // Payload limit exceeded: drop this byte.
                                r_err   <= 1'b1;
                                r_state <= ST_FLUSH;
                            end else begin
                                r_byte       <= w_byte_next;
                                r_byte_valid <= 1'b1;
                                r_byte_last  <= frame_n;
                                r_byte_cnt   <= r_byte_cnt + 1'b1;
                                if (frame_n) begin
                                    r_busy  <= 1'b0;
                                    r_state <= ST_IDLE;
                                end
                            end
                        end else if (frame_n) begin
                            // Frame ended on a partial byte.
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else if (frame_n) begin
                        // Frame ended without a final data bit.
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                ST_FLUSH: begin
                    if (frame_n) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign addr_o       = r_addr;
    assign addr_valid_o = r_addr_valid;
    assign byte_o       = r_byte;
    assign byte_valid_o = r_byte_valid;
    assign byte_last_o  = r_byte_last;
    assign busy_o       = r_busy;
    assign err_o        = r_err;

endmodule : router_input_port
`default_nettype wire

// File: tb/tb_router_input_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_input_port
// Description : Directed self-checking bench for router_input_port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_input_port;

    localparam int PAD  = 5;
    localparam int MAXB = 32;

    logic       clock = 1'b0;
    logic       reset;
    logic       din;
    logic       frame_n;
    logic       valid_n;
    logic [3:0] addr_o;
    logic       addr_valid_o;
    logic [7:0] byte_o;
    logic       byte_valid_o;
    logic       byte_last_o;
    logic       busy_o;
    logic       err_o;

    router_input_port #(
        .PAD_CYCLES (PAD),
        .MAX_BYTES  (MAXB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .din          (din),
        .frame_n      (frame_n),
        .valid_n      (valid_n),
        .addr_o       (addr_o),
        .addr_valid_o (addr_valid_o),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid_o),
        .byte_last_o  (byte_last_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Output monitor, sampled on the falling edge.
    int         cyc     = 0;
    int         err_cnt = 0;
    int         consec  = 0;
    logic       p_err   = 1'b0;
    logic       p_av    = 1'b0;
    logic       p_bv    = 1'b0;
    logic [7:0] bytes_q[$];
    logic       lasts_q[$];
    logic [3:0] addrs_q[$];
    int         byte_cyc_q[$];
    int         addr_cyc_q[$];

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (byte_valid_o) begin
            bytes_q.push_back(byte_o);
            lasts_q.push_back(byte_last_o);
            byte_cyc_q.push_back(cyc);
        end
        if (addr_valid_o) begin
            addrs_q.push_back(addr_o);
            addr_cyc_q.push_back(cyc);
        end
        if (err_o) err_cnt <= err_cnt + 1;
        if ((err_o && p_err) || (addr_valid_o && p_av) || (byte_valid_o && p_bv))
            consec <= consec + 1;
        p_err <= err_o;
        p_av  <= addr_valid_o;
        p_bv  <= byte_valid_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        bytes_q.delete();
        lasts_q.delete();
        addrs_q.delete();
        byte_cyc_q.delete();
        addr_cyc_q.delete();
    endtask

    // Inputs are applied 1 time unit after a rising edge and held until the next.
    task automatic drive(input logic f, input logic v, input logic d);
        frame_n = f;
        valid_n = v;
        din     = d;
        @(posedge clock);
        #1;
    endtask

    task automatic send_addr(input logic [3:0] a);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, a[i]);
    endtask

    task automatic send_pad();
        repeat (PAD) drive(1'b0, 1'b1, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input int bub);
        for (int i = 0; i < 8; i++) begin
            if (i == 1) repeat (bub) drive(1'b0, 1'b1, 1'b0);
            drive((last && i == 7) ? 1'b1 : 1'b0, 1'b0, b[i]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b1, 1'b0);
    endtask

    int err_base;

    initial begin
        reset   = 1'b1;
        frame_n = 1'b1;
        valid_n = 1'b1;
        din     = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("rst_addr",  {28'd0, addr_o}, 32'h0);
        check("rst_byte",  {24'd0, byte_o}, 32'h0);
        check("rst_busy",  {31'd0, busy_o}, 32'h0);
        check("rst_pulse", {29'd0, err_o, addr_valid_o, byte_valid_o}, 32'h0);
        reset = 1'b0;
        idle(2);

        // Basic packet: addr A, bytes 3C, F0
        clear_mon();
        err_base = err_cnt;
        send_addr(4'hA);
        check("t1_addr_valid", {31'd0, addr_valid_o}, 32'h1);
        check("t1_addr",       {28'd0, addr_o},       32'hA);
        check("t1_busy",       {31'd0, busy_o},       32'h1);
        send_pad();
        send_byte(8'h3C, 1'b0, 0);
        send_byte(8'hF0, 1'b1, 0);
        check("t1_busy_end",   {31'd0, busy_o},       32'h0);
        idle(2);
        check("t1_nbytes", bytes_q.size(), 32'd2);
        check("t1_b0",     {24'd0, bytes_q[0]}, 32'h3C);
        check("t1_b1",     {24'd0, bytes_q[1]}, 32'hF0);
        check("t1_lasts",  {30'd0, lasts_q[0], lasts_q[1]}, 32'h1);
        check("t1_err",    err_cnt - err_base, 32'd0);
        check("t1_delay",  byte_cyc_q[0] - addr_cyc_q[0], 32'd13);

        // Same packet with 3 bubbles inside byte 0
        clear_mon();
        err_base = err_cnt;
        send_addr(4'hA);
        send_pad();
        send_byte(8'h3C, 1'b0, 3);
        send_byte(8'hF0, 1'b1, 0);
        idle(2);
        check("t2_nbytes", bytes_q.size(), 32'd2);
        check("t2_b0",     {24'd0, bytes_q[0]}, 32'h3C);
        check("t2_b1",     {24'd0, bytes_q[1]}, 32'hF0);
        check("t2_err",    err_cnt - err_base, 32'd0);
        check("t2_delay",  byte_cyc_q[0] - addr_cyc_q[0], 32'd16);

        // 12-bit payload: one byte then a partial nibble
        clear_mon();
        err_base = err_cnt;
        send_addr(4'h6);
        send_pad();
        send_byte(8'h5A, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check("t3_err_pulse", {31'd0, err_o},  32'h1);
        check("t3_busy",      {31'd0, busy_o}, 32'h0);
        idle(2);
        check("t3_nbytes", bytes_q.size(), 32'd1);
        check("t3_b0",     {24'd0, bytes_q[0]}, 32'h5A);
        check("t3_last",   {31'd0, lasts_q[0]}, 32'h0);
        check("t3_err",    err_cnt - err_base, 32'd1);

        // valid_n low in pad cycle 2
        clear_mon();
        err_base = err_cnt;
        send_addr(4'h5);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check("t4_err_pulse", {31'd0, err_o},  32'h1);
        repeat (6) drive(1'b0, 1'b0, 1'b1);
        check("t4_busy_flush", {31'd0, busy_o}, 32'h1);
        drive(1'b1, 1'b1, 1'b0);
        check("t4_busy_end",   {31'd0, busy_o}, 32'h0);
        idle(1);
        check("t4_nbytes", bytes_q.size(), 32'd0);
        check("t4_err",    err_cnt - err_base, 32'd1);

        // Back-to-back packets
        clear_mon();
        err_base = err_cnt;
        send_addr(4'h2);
        send_pad();
        send_byte(8'h81, 1'b1, 0);
        send_addr(4'h9);
        send_pad();
        send_byte(8'h7E, 1'b1, 0);
        idle(2);
        check("t5_naddr", addrs_q.size(), 32'd2);
        check("t5_addrs", {24'd0, addrs_q[0], addrs_q[1]}, 32'h29);
        check("t5_bytes", {16'd0, bytes_q[0], bytes_q[1]}, 32'h817E);
        check("t5_lasts", {30'd0, lasts_q[0], lasts_q[1]}, 32'h3);
        check("t5_err",   err_cnt - err_base, 32'd0);

        // 33-byte packet overflows MAX_BYTES=32
        clear_mon();
        err_base = err_cnt;
        send_addr(4'hC);
        send_pad();
        for (int k = 0; k < 33; k++) send_byte(8'(k), (k == 32) ? 1'b1 : 1'b0, 0);
        check("t6_err_pulse", {31'd0, err_o},  32'h1);
        check("t6_busy_flush", {31'd0, busy_o}, 32'h1);
        drive(1'b1, 1'b1, 1'b0);
        check("t6_busy_end", {31'd0, busy_o}, 32'h0);
        idle(1);
        check("t6_nbytes", bytes_q.size(), 32'd32);
        check("t6_b0",     {24'd0, bytes_q[0]},  32'h00);
        check("t6_b31",    {24'd0, bytes_q[31]}, 32'h1F);
        check("t6_err",    err_cnt - err_base, 32'd1);
        begin
            int nl = 0;
            foreach (lasts_q[j]) if (lasts_q[j]) nl++;
            check("t6_nlast", nl, 32'd0);
        end

        // Reset during byte 1, then a fresh packet to addr 3
        clear_mon();
        err_base = err_cnt;
        send_addr(4'h7);
        send_pad();
        send_byte(8'h11, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        check("t7_rst_busy", {31'd0, busy_o}, 32'h0);
        check("t7_rst_addr", {28'd0, addr_o}, 32'h0);
        check("t7_rst_byte", {24'd0, byte_o}, 32'h0);
        idle(2);
        send_addr(4'h3);
        check("t7_addr", {28'd0, addr_o}, 32'h3);
        send_pad();
        send_byte(8'hA5, 1'b0, 0);
        send_byte(8'h0F, 1'b1, 0);
        idle(2);
        check("t7_err",   err_cnt - err_base, 32'd0);
        check("t7_nbyte", bytes_q.size(), 32'd3);
        check("t7_bytes", {8'd0, bytes_q[0], bytes_q[1], bytes_q[2]}, 32'h11A50F);
        check("t7_lasts", {29'd0, lasts_q[0], lasts_q[1], lasts_q[2]}, 32'h1);

        check("pulse_consec", consec, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_router_input_port
`default_nettype wire
